// File: rtl/lru_req_frontend.sv
// Request front end for a 4-way LRU grant arbiter: buffers one payload per client,
// runs one arbitration per transfer, forwards the granted payload and counts malformed grants.
module lru_req_frontend #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int ERR_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        cl_valid,
   output logic [N_REQ-1:0]        cl_ready,
   input  logic [N_REQ*DATA_W-1:0] cl_data,
   output logic                    arb_enable,
   output logic [N_REQ-1:0]        arb_req,
   input  logic [N_REQ-1:0]        arb_gnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [1:0]              out_id,
   output logic                    gnt_err,
   output logic [ERR_W-1:0]        err_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_SEND} state_t;

   state_t                         state_q, state_d;
   logic [N_REQ-1:0]               pending_q, pending_d;
   logic [N_REQ-1:0]               cl_ready_q, cl_ready_d;
   logic [N_REQ-1:0][DATA_W-1:0]   hold_q, hold_d;
   logic [1:0]                     id_q, id_d;
   logic [ERR_W-1:0]               err_cnt_q, err_cnt_d;

   logic [N_REQ-1:0]               capture;
   logic                           gnt_ok;
   logic [1:0]                     gnt_id;

   // A grant is usable only if it is one-hot and names a client that is actually waiting.
   always_comb begin
      gnt_id = 2'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) gnt_id = 2'(i);
      end
      gnt_ok = (arb_gnt != '0)
            && ((arb_gnt & (arb_gnt - N_REQ'(1))) == '0)
            && ((arb_gnt & ~pending_q) == '0);
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      hold_d     = hold_q;
      id_d       = id_q;
      err_cnt_d  = err_cnt_q;
      arb_enable = 1'b0;
      gnt_err    = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_id     = 2'd0;

      capture = cl_valid & cl_ready_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (capture[i]) begin
            hold_d[i]    = cl_data[i*DATA_W +: DATA_W];
            pending_d[i] = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (pending_q != '0) state_d = S_ARB;
         end
         S_ARB: begin
            arb_enable = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (gnt_ok) begin
               id_d    = gnt_id;
               state_d = S_SEND;
            end else begin
               gnt_err = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            out_valid = 1'b1;
            out_data  = hold_q[id_q];
            out_id    = id_q;
            // The slot being sent is not ready, so this release never collides with a capture into it.
            if (out_ready) begin
               pending_d[id_q] = 1'b0;
               state_d         = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Tracks the next pending value so a slot closes in the same cycle it is captured.
      cl_ready_d = ~pending_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         cl_ready_q <= '1;
         // NOTE: the holding registers are reset too, so no payload from before a reset can ever be forwarded.
         hold_q     <= '0;
         id_q       <= 2'd0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         cl_ready_q <= cl_ready_d;
         hold_q     <= hold_d;
         id_q       <= id_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign cl_ready = cl_ready_q;
   assign arb_req  = pending_q;
   assign err_cnt  = err_cnt_q;

endmodule
